// File: rtl/aer_event_encoder.sv
// AER encoder: one-hot row/col grants become timestamped address-event
// words, buffered in a first-word-fall-through FIFO for the readout link.
module aer_event_encoder #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int XW = $clog2(ROWS),
  localparam int YW = $clog2(COLS),
  localparam int EW = TS_WIDTH + XW + YW + 1,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          enable_i,
  input  logic [ROWS-1:0] x_gnt_i,
  input  logic [COLS-1:0] y_gnt_i,
  input  logic          polarity_i,
  output logic [EW-1:0] event_o,
  output logic          event_valid_o,
  input  logic          event_ready_i,
  output logic          full_o,
  output logic [LW-1:0] level_o,
  output logic [15:0]   drop_cnt_o,
  output logic [15:0]   err_cnt_o
);

  logic [TS_WIDTH-1:0] ts_q;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic [15:0]         drop_q, err_q;

  logic [XW-1:0] x_addr;
  logic [YW-1:0] y_addr;
  logic [EW-1:0] word_d;
  logic          idle, good, bad;
  logic          pop, push, drop;

  always_comb begin
    x_addr = '0;
    for (int i = 0; i < ROWS; i++)
      if (x_gnt_i[i]) x_addr = x_addr | XW'(i);
  end

  always_comb begin
    y_addr = '0;
    for (int j = 0; j < COLS; j++)
      if (y_gnt_i[j]) y_addr = y_addr | YW'(j);
  end

  assign word_d = {ts_q, x_addr, y_addr, polarity_i};

  assign idle = (x_gnt_i == '0) && (y_gnt_i == '0);
  assign good = enable_i && $onehot(x_gnt_i) && $onehot(y_gnt_i);
  assign bad  = enable_i && !idle && !good;

  // A full FIFO still takes a word if the head leaves on the same edge
  assign pop  = (level_q != '0) && event_ready_i;
  assign push = good && ((level_q < LW'(FIFO_DEPTH)) || pop);
  assign drop = good && !push;

  always_comb begin
    level_d = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      drop_q  <= '0;
      err_q   <= '0;
    end else begin
      ts_q    <= ts_q + TS_WIDTH'(1);
      level_q <= level_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (drop && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
      if (bad && err_q != 16'hFFFF)
        err_q <= err_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && push) mem_q[wptr_q] <= word_d;
  end

  assign event_valid_o = (level_q != '0);
  // Gate the head so stale storage never shows after reset
  assign event_o       = event_valid_o ? mem_q[rptr_q] : '0;
  assign full_o        = (level_q == LW'(FIFO_DEPTH));
  assign level_o       = level_q;
  assign drop_cnt_o    = drop_q;
  assign err_cnt_o     = err_q;

endmodule

// File: tb/tb_aer_event_encoder.sv
// Directed bench for aer_event_encoder with a queue scoreboard
// of expected words checked whenever the DUT hands one over.
module tb_aer_event_encoder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [7:0]  x_gnt_i;
  logic [7:0]  y_gnt_i;
  logic        polarity_i;
  logic [22:0] event_o;
  logic        event_valid_o;
  logic        event_ready_i;
  logic        full_o;
  logic [2:0]  level_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] err_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] tsm = '0;
  logic [22:0] sb [$];

  aer_event_encoder dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .enable_i(enable_i),
    .x_gnt_i(x_gnt_i),
    .y_gnt_i(y_gnt_i),
    .polarity_i(polarity_i),
    .event_o(event_o),
    .event_valid_o(event_valid_o),
    .event_ready_i(event_ready_i),
    .full_o(full_o),
    .level_o(level_o),
    .drop_cnt_o(drop_cnt_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i)
    tsm <= reset_i ? 16'h0 : tsm + 16'h1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] idx8(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic grant(input logic [7:0] x,
                       input logic [7:0] y,
                       input logic p,
                       input bit exp_push);
    x_gnt_i    = x;
    y_gnt_i    = y;
    polarity_i = p;
    if (exp_push)
      sb.push_back({tsm, idx8(x), idx8(y), p});
  endtask

  task automatic idle_gnt();
    x_gnt_i    = '0;
    y_gnt_i    = '0;
    polarity_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (!reset_i && event_valid_o && event_ready_i) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_unexpected: got %0h expected none",
               event_o);
      end else begin
        chk("sb_word", 64'(event_o), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i       = 1'b1;
    enable_i      = 1'b0;
    event_ready_i = 1'b0;
    idle_gnt();
    step();
    step();
    chk("rst_valid", 64'(event_valid_o), 0);
    chk("rst_event", 64'(event_o), 0);
    chk("rst_full", 64'(full_o), 0);
    chk("rst_level", 64'(level_o), 0);
    chk("rst_drop", 64'(drop_cnt_o), 0);
    chk("rst_err", 64'(err_cnt_o), 0);

    // 1: single event at ts 5
    reset_i       = 1'b0;
    enable_i      = 1'b1;
    event_ready_i = 1'b1;
    for (int n = 0; n < 100 && tsm != 16'd5; n++) step();
    grant(8'h80, 8'h04, 1'b1, 1);
    step();
    idle_gnt();
    chk("t1_valid", 64'(event_valid_o), 1);
    chk("t1_word", 64'(event_o), 64'h2F5);
    step();
    chk("t1_valid_drop", 64'(event_valid_o), 0);
    chk("t1_level", 64'(level_o), 0);

    // 2: back-pressure and overflow
    event_ready_i = 1'b0;
    for (int r = 0; r < 6; r++) begin
      grant(8'(1 << r), 8'h01, 1'b0, r < 4);
      step();
    end
    idle_gnt();
    chk("t2_level", 64'(level_o), 4);
    chk("t2_full", 64'(full_o), 1);
    chk("t2_drop", 64'(drop_cnt_o), 2);
    step();
    step();
    chk("t2_hold", 64'(event_o), 64'(sb[0]));
    event_ready_i = 1'b1;
    for (int n = 0; n < 4; n++) step();
    chk("t2_drained", 64'(level_o), 0);

    // 3: full with push and pop on the same edge
    event_ready_i = 1'b0;
    for (int r = 0; r < 4; r++) begin
      grant(8'(1 << r), 8'h02, 1'b1, 1);
      step();
    end
    chk("t3_full", 64'(full_o), 1);
    event_ready_i = 1'b1;
    grant(8'h40, 8'h02, 1'b1, 1);
    step();
    idle_gnt();
    chk("t3_level", 64'(level_o), 4);
    chk("t3_drop", 64'(drop_cnt_o), 2);
    for (int n = 0; n < 4; n++) step();
    chk("t3_drained", 64'(level_o), 0);

    // 4: malformed grants
    grant(8'h03, 8'h01, 1'b0, 0);
    step();
    chk("t4_err1", 64'(err_cnt_o), 1);
    chk("t4_nopush1", 64'(level_o), 0);
    grant(8'h00, 8'h10, 1'b0, 0);
    step();
    chk("t4_err2", 64'(err_cnt_o), 2);
    chk("t4_nopush2", 64'(level_o), 0);
    idle_gnt();
    step();
    chk("t4_idle_err", 64'(err_cnt_o), 2);
    chk("t4_idle_lvl", 64'(level_o), 0);

    // 5: enable gating
    enable_i = 1'b0;
    grant(8'h10, 8'h20, 1'b1, 0);
    for (int n = 0; n < 10; n++) step();
    chk("t5_level", 64'(level_o), 0);
    chk("t5_err", 64'(err_cnt_o), 2);
    chk("t5_drop", 64'(drop_cnt_o), 2);
    enable_i = 1'b1;
    grant(8'h10, 8'h20, 1'b1, 1);
    step();
    idle_gnt();
    chk("t5_valid", 64'(event_valid_o), 1);
    step();

    // 6a: reset with level 3 and a push pending
    event_ready_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      grant(8'(1 << r), 8'h08, 1'b0, 1);
      step();
    end
    chk("t6_level3", 64'(level_o), 3);
    reset_i = 1'b1;
    sb.delete();
    grant(8'h80, 8'h80, 1'b1, 0);
    step();
    reset_i = 1'b0;
    idle_gnt();
    chk("t6_valid", 64'(event_valid_o), 0);
    chk("t6_event", 64'(event_o), 0);
    chk("t6_full", 64'(full_o), 0);
    chk("t6_level", 64'(level_o), 0);
    chk("t6_drop", 64'(drop_cnt_o), 0);
    chk("t6_err", 64'(err_cnt_o), 0);

    // 6b: timestamp wrap
    event_ready_i = 1'b1;
    for (int n = 0; n < 70000 && tsm != 16'hFFFF; n++)
      step();
    grant(8'h02, 8'h40, 1'b1, 1);
    step();
    chk("t6_ts_ffff", 64'(event_o[22:7]), 64'hFFFF);
    grant(8'h04, 8'h01, 1'b0, 1);
    step();
    idle_gnt();
    chk("t6_ts_0000", 64'(event_o[22:7]), 0);
    step();
    step();
    chk("end_level", 64'(level_o), 0);
    chk("end_sb", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aer_event_encoder.md
# aer_event_encoder

- Sits directly downstream of `top_arb` in the event-camera readout path.
- Consumes each cycle's one-hot row/column grant and polarity bit.
- Encodes them into a binary address-event (AER) word stamped with a free-running timestamp.
- Buffers the words in a first-word-fall-through FIFO and presents them to the readout link over a valid/ready handshake, counting malformed grants and overflow drops.

## Interface
- `ROWS`, 8: pixel rows; must be a power of two ≥ 2.
- `COLS`, 8: pixel columns; must be a power of two ≥ 2.
- `TS_WIDTH`, 16: timestamp width.
- `FIFO_DEPTH`, 4: event buffer entries; must be a power of two ≥ 2.
- `EW`, derived: event word width = TS_WIDTH + log2(ROWS) + log2(COLS) + 1.
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk_i`  in  1  system clock.
  - `reset_i`  in  1  synchronous active-high reset.
- `enable_i`  in  1  capture enable (same signal that drives the arbiter).
- `x_gnt_i`  in  ROWS  one-hot row grant from arbiter.
- `y_gnt_i`  in  COLS  one-hot column grant from arbiter.
- `polarity_i`  in  1  polarity of granted pixel (1 = ON, 0 = OFF).
- `event_o`  out  EW  head-of-FIFO event word: {ts, x_addr, y_addr, pol}, pol at bit 0.
- `event_valid_o`  out  1  `event_o` is valid.
- `event_ready_i`  in  1  consumer accepts `event_o` this cycle.
- `full_o`  out  1  FIFO holds FIFO_DEPTH entries.
- `level_o`  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- `drop_cnt_o`  out  16  saturating count of events lost to overflow.
- `err_cnt_o`  out  16  saturating count of malformed grants.

## Operation
- **Timestamp counter `ts_q`**
  - 0 while `reset_i` is high; +1 on every other edge, independent of `enable_i`.
  - Wraps from 2^TS_WIDTH−1 to 0 with no flag.
- **Grant classification**, on each edge with `enable_i`=1:
  - Both vectors zero: idle, no action.
  - Both vectors exactly one-hot: valid event.
  - Anything else (one vector zero and the other nonzero, or either vector with >1 bit set): malformed; `err_cnt_o` +1 (saturates at 0xFFFF); nothing pushed.
- **Encoding**
  - x_addr = index of the set bit of `x_gnt_i`; y_addr = index of the set bit of `y_gnt_i`.
  - Word = {ts_q (pre-edge value), x_addr, y_addr, polarity_i}.
  - Every cycle carrying a valid grant is one event; no duplicate suppression.
- **`enable_i`=0**: grants are ignored and neither counter changes. The FIFO keeps draining.
- **Push**: accepted when level < FIFO_DEPTH, or when level = FIFO_DEPTH and a pop occurs on the same edge.
  - Otherwise the event is dropped and `drop_cnt_o` +1 (saturates at 0xFFFF).
- **Pop**: occurs when `event_valid_o` && `event_ready_i`.
- **Simultaneous push and pop**: level unchanged.
- **Pointers**: read and write pointers wrap modulo FIFO_DEPTH.
- **Output**
  - `event_valid_o` = (level ≠ 0).
  - `event_o` = entry at the read pointer; it holds stable while valid && !ready.
- **Reset**: takes effect at the next edge regardless of operation in progress.
  - FIFO is flushed, both counters are cleared, ts_q = 0.
  - Any in-flight event and any push on that edge are discarded.

## Timing
- **Reset values**: `event_valid_o`=0, `event_o`=0, `full_o`=0, `level_o`=0, `drop_cnt_o`=0, `err_cnt_o`=0.
- **Capture latency**: a grant sampled at edge N is on `event_o` with `event_valid_o`=1 in the cycle after edge N, provided the FIFO was empty. There is no combinational path from grant inputs to outputs.
- **Handshake**: `event_ready_i` may be combinational from the consumer. Pop and push take effect at the same edge.
- **Status outputs**: `full_o`, `level_o` and both counters update at the edge that causes the change.
- **Throughput**: sustains one event per cycle when `event_ready_i` is held high.

## Test plan
Configuration: ROWS=COLS=8, TS_WIDTH=16, FIFO_DEPTH=4.

1. **Single event**: reset, then `enable_i`=1, `event_ready_i`=1. At the edge where ts_q=5, drive x_gnt=8'h80, y_gnt=8'h04, pol=1 → next cycle `event_valid_o`=1, `event_o`=23'h0002F5. Valid drops after one cycle; level returns to 0.
2. **Back-pressure and overflow**: `event_ready_i`=0; six consecutive valid grants, rows 0..5, col 0, pol 0 → level=4, `full_o`=1, `drop_cnt_o`=2. Then raise ready → four words pop in order (x_addr 0,1,2,3) with timestamps consecutive; `event_o` stable while ready was low.
3. **Full with simultaneous push and pop**: fill to 4, then assert ready and a valid grant on the same edge → level stays 4, `drop_cnt_o` unchanged, new word last out.
4. **Malformed grants**:
   - x_gnt=8'h03, y_gnt=8'h01 → `err_cnt_o`=1, no push.
   - x_gnt=8'h00, y_gnt=8'h10 → `err_cnt_o`=2, no push.
   - Both vectors zero → no change.
5. **Enable gating**: `enable_i`=0 with valid grants for 10 cycles → no pushes, counters unchanged, ts_q advances by 10; the word captured after re-enable carries the advanced timestamp.
6. **Reset mid-operation and wrap**:
   - With level=3 and `drop_cnt_o`≠0, pulse `reset_i` one cycle → next cycle all outputs are at reset values.
   - Separately, run 65536 cycles → an event captured at ts_q=16'hFFFF, then the next one at 16'h0000.
